// File: rtl/spi_master_cfg.sv
// Configurable SPI master: runtime CPOL/CPHA, bit order, SCK divider and decoded chip selects.
// One word per transfer, framed by one half-period of CS setup and hold.
module spi_master_cfg #(
    parameter int DATA_W   = 16,
    parameter int DIV_W    = 8,
    parameter int NUM_CS   = 2,
    parameter int CS_SEL_W = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [CS_SEL_W-1:0] cs_sel,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                lsb_first,
    input  logic [DIV_W-1:0]    clk_div,
    input  logic                miso,
    output logic                mosi,
    output logic                sck,
    output logic [NUM_CS-1:0]   cs_n,
    output logic [DATA_W-1:0]   data_out,
    output logic                busy,
    output logic                done
);

    localparam int EC_W = $clog2(2 * DATA_W);
    localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        XFER     = 2'd2,
        CS_HOLD  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    cnt;
    logic [DIV_W-1:0]    div_q;
    logic [EC_W-1:0]     edge_cnt;
    logic                cpha_q;
    logic                lsb_q;
    logic [DATA_W-1:0]   tx_q;
    logic [DATA_W-1:0]   rx_q;
    logic                accept;
    logic                expire;
    logic                last_edge;
    logic                leading;
    logic                drive;
    logic                sample;

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                   input logic lsb);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    // Out-of-range selects leave every chip select deasserted.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_SEL_W-1:0] sel);
        logic [NUM_CS-1:0] r;
        r = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(sel) == i) r[i] = 1'b0;
        end
        return r;
    endfunction

    assign accept    = (state == IDLE) && start;
    assign expire    = (cnt == '0);
    assign last_edge = (edge_cnt == LAST_EDGE);
    assign leading   = ~edge_cnt[0];
    // cpha=0 preloads the first bit at accept, so it never drives after the final trailing edge.
    assign drive     = cpha_q ? leading : (~leading && !last_edge);
    assign sample    = cpha_q ? ~leading : leading;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = CS_SETUP;
            CS_SETUP: if (expire) state_nxt = XFER;
            XFER:     if (expire && last_edge) state_nxt = CS_HOLD;
            CS_HOLD:  if (expire) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            edge_cnt <= '0;
            sck      <= 1'b0;
            cs_n     <= '1;
            mosi     <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE) cnt <= expire ? div_q : cnt - DIV_W'(1);
            case (state)
                IDLE: begin
                    sck      <= cpol;
                    cs_n     <= '1;
                    edge_cnt <= '0;
                    if (start) begin
                        cnt  <= clk_div;
                        cs_n <= cs_decode(cs_sel);
                        if (!cpha) mosi <= first_bit(data_in, lsb_first);
                    end
                end
                XFER: begin
                    if (expire) begin
                        sck      <= ~sck;
                        edge_cnt <= edge_cnt + EC_W'(1);
                        if (drive) mosi <= first_bit(tx_q, lsb_q);
                    end
                end
                CS_HOLD: begin
                    if (expire) begin
                        cs_n     <= '1;
                        done     <= 1'b1;
                        data_out <= rx_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Shadow configuration and shift registers; fully reloaded on every accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            div_q  <= clk_div;
            cpha_q <= cpha;
            lsb_q  <= lsb_first;
            tx_q   <= cpha ? data_in : shift_out(data_in, lsb_first);
        end else if (state == XFER && expire) begin
            if (drive)  tx_q <= shift_out(tx_q, lsb_q);
            if (sample) rx_q <= shift_in(rx_q, miso, lsb_q);
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: vector table of full transfers plus
// back-to-back and mid-transfer-reset sequences, checked against a behavioural slave.
module tb_spi_master_cfg;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic [1:0]  cs_sel;
    logic        cpol;
    logic        cpha;
    logic        lsb_first;
    logic [7:0]  clk_div;
    logic        miso;
    logic        mosi;
    logic        sck;
    logic [1:0]  cs_n;
    logic [15:0] data_out;
    logic        busy;
    logic        done;

    logic        loopback;
    logic        slave_miso;
    logic        s_en;
    logic        s_cpha;
    logic        s_lsb;
    logic [15:0] s_word;
    logic [15:0] slave_rx;
    logic        last_sck;
    int          s_edges;
    int          s_bit;

    int n_vec;
    int n_err;

    typedef struct {
        logic        cpol;
        logic        cpha;
        logic        lsb;
        logic [7:0]  div;
        logic [15:0] data;
        logic [1:0]  cs;
        logic [15:0] sword;
        logic        loop;
        logic [15:0] exp_dout;
        int          exp_busy;
        logic [1:0]  exp_cs;
    } vec_t;

    vec_t vecs[8];

    spi_master_cfg #(
        .DATA_W(16), .DIV_W(8), .NUM_CS(2), .CS_SEL_W(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .cs_sel(cs_sel),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
        .miso(miso), .mosi(mosi), .sck(sck), .cs_n(cs_n), .data_out(data_out),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign miso = loopback ? mosi : slave_miso;

    function automatic logic txbit(input logic [15:0] w, input int k, input logic lsb);
        return lsb ? w[k] : w[15-k];
    endfunction

    // Behavioural slave: edge parity gives leading/trailing regardless of CPOL.
    always @(sck or s_en or s_cpha or s_lsb or s_word) begin
        if (!s_en) begin
            s_edges    = 0;
            slave_rx   = '0;
            slave_miso = s_cpha ? 1'b0 : txbit(s_word, 0, s_lsb);
            s_bit      = s_cpha ? 0 : 1;
        end else if (sck !== last_sck) begin
            s_edges++;
            if ((s_edges % 2 == 1) == s_cpha) begin
                if (s_bit < 16) slave_miso = txbit(s_word, s_bit, s_lsb);
                s_bit++;
            end else begin
                slave_rx = s_lsb ? {mosi, slave_rx[15:1]} : {slave_rx[14:0], mosi};
            end
        end
        last_sck = sck;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        int          busy_c, cs_c, cs_bad, rises, extra_done;
        logic        prev_sck, got;
        logic [15:0] dout;
        busy_c = 0; cs_c = 0; cs_bad = 0; rises = 0; extra_done = 0;
        got = 1'b0; dout = '0;
        @(negedge clk);
        s_en = 1'b0;
        cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb; clk_div = v.div;
        data_in = v.data; cs_sel = v.cs; loopback = v.loop;
        s_cpha = v.cpha; s_lsb = v.lsb; s_word = v.sword;
        @(negedge clk);
        check("idle_sck", {31'd0, sck}, {31'd0, v.cpol});
        s_en  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prev_sck = sck;
        for (int c = 0; c < 20000 && !got; c++) begin
            if (busy) busy_c++;
            if (busy && cs_n == v.exp_cs) cs_c++;
            if ((busy && cs_n != v.exp_cs) || (!busy && cs_n != 2'b11)) cs_bad++;
            if (sck && !prev_sck) rises++;
            prev_sck = sck;
            if (done) begin
                got  = 1'b1;
                dout = data_out;
            end else begin
                @(negedge clk);
            end
        end
        check("done_seen", {31'd0, got}, 32'd1);
        check("data_out", {16'd0, dout}, {16'd0, v.exp_dout});
        check("busy_cycles", busy_c, v.exp_busy);
        check("cs_active_cycles", cs_c, v.exp_busy);
        check("cs_wrong_cycles", cs_bad, 0);
        check("sck_rises", rises, 16);
        check("slave_rx_mosi", {16'd0, slave_rx}, {16'd0, v.data});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check("done_single", extra_done, 0);
        check("sck_end_idle", {31'd0, sck}, {31'd0, v.cpol});
        s_en = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; data_in = '0; cs_sel = '0; cpol = 1'b0; cpha = 1'b0;
        lsb_first = 1'b0; clk_div = '0; loopback = 1'b0; s_en = 1'b0;
        s_cpha = 1'b0; s_lsb = 1'b0; s_word = '0;

        //            cpol cpha lsb  div     data      cs     sword     loop  exp_dout  busy  exp_cs
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'd0,   16'hA55A, 2'd0, 16'h0000, 1'b1, 16'hA55A, 34,   2'b10};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'd3,   16'hC3F0, 2'd1, 16'h1234, 1'b0, 16'h1234, 136,  2'b01};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 8'd1,   16'h0001, 2'd0, 16'h8000, 1'b0, 16'h8000, 68,   2'b10};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'd2,   16'h8001, 2'd0, 16'h00FF, 1'b0, 16'h00FF, 102,  2'b10};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'd0,   16'h5A5A, 2'd3, 16'h0F0F, 1'b0, 16'h0F0F, 34,   2'b11};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 8'd255, 16'hFFFF, 2'd1, 16'h7FFE, 1'b0, 16'h7FFE, 8704, 2'b01};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 8'd0,   16'h1234, 2'd1, 16'h4321, 1'b0, 16'h4321, 34,   2'b01};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 8'd2,   16'h00F1, 2'd2, 16'hE00D, 1'b0, 16'hE00D, 102,  2'b11};

        repeat (3) @(negedge clk);
        check("rst_cs_n", {30'd0, cs_n}, 32'h3);
        check("rst_sck", {31'd0, sck}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_data_out", {16'd0, data_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

        // Back-to-back words with start held high, mode 2, clk_div=1.
        begin
            int   dones, words, busy_c, gap_run, ngaps, bad_gap, late_busy;
            logic prev_busy, seen_low;
            dones = 0; words = 0; busy_c = 0; gap_run = 0; ngaps = 0; bad_gap = 0;
            late_busy = 0; prev_busy = 1'b0; seen_low = 1'b0;
            @(negedge clk);
            cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd1;
            data_in = 16'h3C96; cs_sel = 2'd0; loopback = 1'b1;
            @(negedge clk);
            start = 1'b1;
            for (int c = 0; c < 2000 && dones < 3; c++) begin
                if (busy && !prev_busy) words++;
                prev_busy = busy;
                if (busy) busy_c++;
                if (cs_n[0] && seen_low) gap_run++;
                if (!cs_n[0]) begin
                    if (gap_run > 0) begin
                        ngaps++;
                        if (gap_run != 1) bad_gap++;
                    end
                    gap_run  = 0;
                    seen_low = 1'b1;
                end
                if (done) begin
                    dones++;
                    check("b2b_data_out", {16'd0, data_out}, 32'h3C96);
                    if (dones == 3) start = 1'b0;
                end
                @(negedge clk);
            end
            for (int c = 0; c < 5; c++) begin
                if (busy) late_busy++;
                @(negedge clk);
            end
            check("b2b_dones", dones, 3);
            check("b2b_words", words, 3);
            check("b2b_gaps", ngaps, 2);
            check("b2b_gap_len", bad_gap, 0);
            check("b2b_busy_cycles", busy_c, 204);
            check("b2b_idle_after", late_busy, 0);
        end

        // Reset around half-period 10 of a mode-2 transfer.
        begin
            int extra;
            extra = 0;
            @(negedge clk);
            cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd3;
            data_in = 16'hBEEF; cs_sel = 2'd1; loopback = 1'b1;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (38) @(negedge clk);
            check("pre_rst_busy", {31'd0, busy}, 32'd1);
            rst = 1'b1;
            @(negedge clk);
            check("mid_rst_cs_n", {30'd0, cs_n}, 32'h3);
            check("mid_rst_sck", {31'd0, sck}, 32'd0);
            check("mid_rst_busy", {31'd0, busy}, 32'd0);
            check("mid_rst_data_out", {16'd0, data_out}, 32'd0);
            check("mid_rst_done", {31'd0, done}, 32'd0);
            rst = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (done || busy) extra++;
            end
            check("post_rst_quiet", extra, 0);
            apply_vec(vecs[1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
Parametrised SPI master, successor to the fixed 16-bit/mode-0 master used for the codec/ADC links on the pedal. Supports:
- Configurable word width.
- All four CPOL/CPHA modes, selected per transfer.
- MSB- or LSB-first shifting.
- A runtime SCK divider.
- Multiple decoded active-low chip selects, with one half-period of CS setup and hold around each word.

Parameters:
DATA_W, 16, transfer word width in bits (>=2)
DIV_W, 8, width of the runtime clock-divider input
NUM_CS, 2, number of chip-select outputs (>=1)
CS_SEL_W, 1, width of cs_sel (must satisfy 2**CS_SEL_W >= NUM_CS)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  request a transfer; accepted only when busy=0
data_in  input  DATA_W  word to transmit; latched on accept
cs_sel  input  CS_SEL_W  chip-select index; latched on accept
cpol  input  1  SCK idle level; latched on accept (drives idle SCK live while IDLE)
cpha  input  1  0 = sample on leading edge, 1 = shift on leading edge; latched on accept
lsb_first  input  1  1 = LSB shifted first; latched on accept
clk_div  input  DIV_W  half-period = clk_div+1 clk cycles; latched on accept
miso  input  1  serial data in
mosi  output  1  serial data out (registered)
sck  output  1  serial clock (registered)
cs_n  output  NUM_CS  active-low chip selects (registered)
data_out  output  DATA_W  last received word
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse when a transfer completes

Behaviour:
- Reset values: cs_n all 1; sck=0; mosi=0; data_out=0; busy=0; done=0; state=IDLE.
- Reset mid-transfer: IDLE next cycle, CS released, no done pulse, data_out cleared.
- States:
  - IDLE -> CS_SETUP on start.
  - CS_SETUP -> XFER after clk_div+1 cycles.
  - XFER -> CS_HOLD after 2*DATA_W SCK edges.
  - CS_HOLD -> IDLE after clk_div+1 cycles.
- Half-period counter: loads clk_div, decrements to 0; each expiry ends a half-period.
- IDLE: sck_q <= cpol each cycle; cs_n all 1; mosi holds its value.
- Accept cycle (IDLE & start):
  - Latch data_in, cs_sel, cpol, cpha, lsb_first, clk_div into shadow registers.
  - Next cycle: state=CS_SETUP; cs_n[cs_sel] low.
  - If cpha=0, mosi = first bit (MSB, or LSB if lsb_first) in that same cycle.
- XFER: sck toggles at each half-period expiry, 2*DATA_W toggles in total. The last toggle returns sck to cpol and enters CS_HOLD.
- Leading edges are odd-numbered toggles; trailing edges are even-numbered.
  - cpha=0: miso sampled on leading; next bit driven on trailing (no drive after the last trailing edge).
  - cpha=1: next bit driven on leading; miso sampled on trailing.
- Sampling takes the miso value present in the clk cycle in which sck_q toggles.
- Receive shift register fills MSB-first or LSB-first to match lsb_first, so the first received bit lands in bit DATA_W-1 or bit 0 respectively.
- CS_HOLD expiry, single cycle:
  - state=IDLE; busy=0; cs_n all 1; data_out <= received word.
  - done=1 for exactly one cycle.
- Timing: busy is high for exactly (2*DATA_W+2)*(clk_div+1) cycles, starting the cycle after accept.
- start is ignored while busy=1. start in the done cycle (state IDLE) is accepted, giving back-to-back words with cs_n high for exactly one cycle between them.
- cs_sel >= NUM_CS: no cs_n asserted; the transfer otherwise runs normally.
- clk_div=0 gives sck = clk/2. clk_div = all ones is legal (no overflow; the counter is DIV_W bits).
- Configuration inputs changing mid-transfer have no effect.

Test Plan:
- Mode 0, clk_div=0, data_in=16'hA55A, miso tied to mosi -> 16 rising edges; data_out=16'hA55A; busy high 34 cycles; done pulses once; cs_n[0] low for 34 cycles.
- Mode 3 (cpol=1, cpha=1), clk_div=3, slave model returns 16'h1234 MSB-first, cs_sel=1 -> sck idles 1; busy 136 cycles; cs_n=2'b01 during transfer; data_out=16'h1234.
- lsb_first=1, mode 1, data_in=16'h0001 -> mosi high only in the first bit slot; slave sending 16'h8000 LSB-first gives data_out=16'h8000.
- start held high continuously, mode 2, clk_div=1 -> consecutive words; cs_n high exactly 1 cycle between words; start pulses during busy are ignored (word count matches done count).
- rst asserted at half-period 10 of a transfer -> next cycle cs_n=all 1, sck=0, busy=0, data_out=0, no done pulse; a subsequent transfer completes correctly.
- cs_sel=3 with NUM_CS=2 (CS_SEL_W=2) -> cs_n stays 2'b11; sck/mosi toggle normally; done pulses.
